// File: rtl/cs_address_sequencer.sv
// rtl/cs_address_sequencer.sv - control-store address sequencer with memory-access stall
module cs_address_sequencer #(
  parameter int DATAWIDTH_JUMPADDRESS = 11,
  parameter int DATAWIDTH_CONDITION   = 3,
  parameter int DATAWIDTH_IR          = 32,
  parameter int DATAWIDTH_FLAGS       = 4
) (
  input  logic                             CS_ADDRESS_SEQUENCER_CLOCK_50,
  input  logic                             CS_ADDRESS_SEQUENCER_ResetInLow_In,
  input  logic [DATAWIDTH_CONDITION-1:0]   CS_ADDRESS_SEQUENCER_Condition_InBus,
  input  logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_JumpAddress_InBus,
  input  logic                             CS_ADDRESS_SEQUENCER_RD_In,
  input  logic                             CS_ADDRESS_SEQUENCER_WR_In,
  input  logic                             CS_ADDRESS_SEQUENCER_MemReady_In,
  input  logic [DATAWIDTH_FLAGS-1:0]       CS_ADDRESS_SEQUENCER_Flags_InBus,
  input  logic [DATAWIDTH_IR-1:0]          CS_ADDRESS_SEQUENCER_IR_InBus,
  output logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_CSAddress_OutBus,
  output logic                             CS_ADDRESS_SEQUENCER_Stalled_Out
);

  localparam int AW = DATAWIDTH_JUMPADDRESS;

  localparam logic [DATAWIDTH_CONDITION-1:0] COND_CSAI   = 3'b000;
  localparam logic [DATAWIDTH_CONDITION-1:0] COND_N      = 3'b001;
  localparam logic [DATAWIDTH_CONDITION-1:0] COND_Z      = 3'b010;
  localparam logic [DATAWIDTH_CONDITION-1:0] COND_V      = 3'b011;
  localparam logic [DATAWIDTH_CONDITION-1:0] COND_C      = 3'b100;
  localparam logic [DATAWIDTH_CONDITION-1:0] COND_IR13   = 3'b101;
  localparam logic [DATAWIDTH_CONDITION-1:0] COND_JUMP   = 3'b110;
  localparam logic [DATAWIDTH_CONDITION-1:0] COND_DECODE = 3'b111;

  // Flag bus is ordered {N,Z,V,C} from MSB to LSB.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cs_address_q, cs_address_d;

  logic [AW-1:0] csai_addr;
  logic [AW-1:0] decode_addr;
  logic [AW-1:0] next_addr;
  logic          jump_taken;
  logic          mem_access;
  logic          mem_ready;
  logic          unused_ir;

  assign mem_access = CS_ADDRESS_SEQUENCER_RD_In | CS_ADDRESS_SEQUENCER_WR_In;
  assign mem_ready  = CS_ADDRESS_SEQUENCER_MemReady_In;

  // Increment wraps naturally at the address width.
  assign csai_addr = cs_address_q + AW'(1);

  // Opcode fields select an entry in the upper half of the control store, 4-word aligned.
  assign decode_addr = AW'({1'b1,
                            CS_ADDRESS_SEQUENCER_IR_InBus[31:30],
                            CS_ADDRESS_SEQUENCER_IR_InBus[24:19],
                            2'b00});

  assign unused_ir = ^{CS_ADDRESS_SEQUENCER_IR_InBus[29:25],
                       CS_ADDRESS_SEQUENCER_IR_InBus[18:14],
                       CS_ADDRESS_SEQUENCER_IR_InBus[12:0]};

  always_comb begin
    jump_taken = 1'b0;
    case (CS_ADDRESS_SEQUENCER_Condition_InBus)
      COND_N:    jump_taken = CS_ADDRESS_SEQUENCER_Flags_InBus[FLAG_N];
      COND_Z:    jump_taken = CS_ADDRESS_SEQUENCER_Flags_InBus[FLAG_Z];
      COND_V:    jump_taken = CS_ADDRESS_SEQUENCER_Flags_InBus[FLAG_V];
      COND_C:    jump_taken = CS_ADDRESS_SEQUENCER_Flags_InBus[FLAG_C];
      COND_IR13: jump_taken = CS_ADDRESS_SEQUENCER_IR_InBus[13];
      COND_JUMP: jump_taken = 1'b1;
      default:   jump_taken = 1'b0;
    endcase
  end

  always_comb begin
    next_addr = csai_addr;
    if (CS_ADDRESS_SEQUENCER_Condition_InBus == COND_DECODE) begin
      next_addr = decode_addr;
    end else if (CS_ADDRESS_SEQUENCER_Condition_InBus != COND_CSAI && jump_taken) begin
      next_addr = CS_ADDRESS_SEQUENCER_JumpAddress_InBus;
    end
  end

  // START holds address 0 for one cycle so the store can fetch microword 0.
  always_comb begin
    state_d      = state_q;
    cs_address_d = cs_address_q;
    case (state_q)
      ST_START: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (mem_access && !mem_ready) begin
          state_d = ST_WAIT;
        end else begin
          cs_address_d = next_addr;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          cs_address_d = next_addr;
          state_d      = ST_RUN;
        end
      end
      default: begin
        state_d      = ST_START;
        cs_address_d = '0;
      end
    endcase
  end

  always_ff @(posedge CS_ADDRESS_SEQUENCER_CLOCK_50 or negedge CS_ADDRESS_SEQUENCER_ResetInLow_In) begin
    if (!CS_ADDRESS_SEQUENCER_ResetInLow_In) begin
      state_q      <= ST_START;
      cs_address_q <= '0;
    end else begin
      state_q      <= state_d;
      cs_address_q <= cs_address_d;
    end
  end

  assign CS_ADDRESS_SEQUENCER_CSAddress_OutBus = cs_address_q;
  assign CS_ADDRESS_SEQUENCER_Stalled_Out      = (state_q == ST_WAIT);

endmodule

// File: tb/tb_cs_address_sequencer.sv
// tb/tb_cs_address_sequencer.sv - scoreboard bench for cs_address_sequencer
module tb_cs_address_sequencer;

  logic        clk;
  logic        rst_n;
  logic [2:0]  cond;
  logic [10:0] jaddr;
  logic        rd;
  logic        wr;
  logic        mem_ready;
  logic [3:0]  flags;
  logic [31:0] ir;
  logic [10:0] cs_addr;
  logic        stalled;

  int checks = 0;
  int errors = 0;

  // Each entry is {stalled, address} expected just after the next rising edge.
  logic [11:0] sb_q[$];

  bit m_started;
  bit m_wait;
  int m_addr;

  cs_address_sequencer dut (
    .CS_ADDRESS_SEQUENCER_CLOCK_50         (clk),
    .CS_ADDRESS_SEQUENCER_ResetInLow_In    (rst_n),
    .CS_ADDRESS_SEQUENCER_Condition_InBus  (cond),
    .CS_ADDRESS_SEQUENCER_JumpAddress_InBus(jaddr),
    .CS_ADDRESS_SEQUENCER_RD_In            (rd),
    .CS_ADDRESS_SEQUENCER_WR_In            (wr),
    .CS_ADDRESS_SEQUENCER_MemReady_In      (mem_ready),
    .CS_ADDRESS_SEQUENCER_Flags_InBus      (flags),
    .CS_ADDRESS_SEQUENCER_IR_InBus         (ir),
    .CS_ADDRESS_SEQUENCER_CSAddress_OutBus (cs_addr),
    .CS_ADDRESS_SEQUENCER_Stalled_Out      (stalled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int ref_next(int addr, int c, int j, logic [3:0] fl, logic [31:0] iv);
    int r;
    r = (addr + 1) % 2048;
    case (c)
      1: if (fl[3]) r = j;
      2: if (fl[2]) r = j;
      3: if (fl[1]) r = j;
      4: if (fl[0]) r = j;
      5: if (iv[13]) r = j;
      6: r = j;
      7: r = 1024 + int'(iv[31:30]) * 256 + int'(iv[24:19]) * 4;
      default: r = (addr + 1) % 2048;
    endcase
    return r;
  endfunction

  task automatic cycle(input logic [2:0] c, input logic [10:0] j, input logic rd_v,
                       input logic wr_v, input logic rdy, input logic [3:0] fl,
                       input logic [31:0] iv);
    logic [11:0] e;
    @(negedge clk);
    cond = c; jaddr = j; rd = rd_v; wr = wr_v; mem_ready = rdy; flags = fl; ir = iv;
    if (!m_started) begin
      m_started = 1'b1;
    end else if ((m_wait || rd_v || wr_v) && !rdy) begin
      m_wait = 1'b1;
    end else begin
      m_addr = ref_next(m_addr, int'(c), int'(j), fl, iv);
      m_wait = 1'b0;
    end
    e = {m_wait, 11'(m_addr)};
    sb_q.push_back(e);
  endtask

  task automatic go(input logic [2:0] c, input int j);
    cycle(c, 11'(j), 1'b0, 1'b0, 1'b1, 4'h0, 32'h0);
  endtask

  task automatic check_reset(input string tag);
    checks++;
    if (cs_addr !== 11'd0 || stalled !== 1'b0) begin
      errors++;
      $display("FAIL %s: addr=%0d stalled=%0b, required addr=0 stalled=0", tag, cs_addr, stalled);
    end
  endtask

  always @(posedge clk) begin
    logic [11:0] e;
    #1;
    if (rst_n && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (cs_addr !== e[10:0] || stalled !== e[11]) begin
        errors++;
        $display("FAIL seq: addr=%0d stalled=%0b, required addr=%0d stalled=%0b at %0t",
                 cs_addr, stalled, e[10:0], e[11], $time);
      end
    end
  end

  initial begin
    logic [31:0] iv;
    rst_n = 1'b0; cond = '0; jaddr = '0; rd = 0; wr = 0; mem_ready = 0; flags = '0; ir = '0;
    m_started = 0; m_wait = 0; m_addr = 0;
    repeat (3) @(posedge clk);
    #3;
    check_reset("reset_state");
    rst_n = 1'b1;

    // START cycle, then increment with a same-cycle completed read
    cycle(3'b000, 11'd0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h0);
    cycle(3'b000, 11'd0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h0);
    iv = 32'h0; iv[31:30] = 2'b10; iv[24:19] = 6'b010000;
    cycle(3'b111, 11'd0, 1'b0, 1'b0, 1'b1, 4'h0, iv);
    iv = 32'h0; iv[13] = 1'b1;
    cycle(3'b101, 11'd1602, 1'b0, 1'b0, 1'b1, 4'h0, iv);
    go(3'b110, 1600);
    cycle(3'b101, 11'd1602, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0);
    go(3'b110, 1600);
    go(3'b110, 1603);

    // Flag conditions: taken and not taken for N, Z, V, C
    for (int k = 0; k < 4; k++) begin
      logic [2:0] c;
      logic [3:0] fl;
      c = (k == 0) ? 3'b001 : (k == 1) ? 3'b010 : (k == 2) ? 3'b011 : 3'b100;
      fl = 4'b1000 >> k;
      go(3'b110, 40);
      cycle(c, 11'd500, 1'b0, 1'b0, 1'b1, ~fl, 32'h0);
      cycle(c, 11'd500, 1'b0, 1'b0, 1'b1, fl, 32'h0);
    end

    // Wrap, self-loop, then a 3-cycle stall from address 0
    go(3'b110, 2047);
    go(3'b000, 0);
    go(3'b110, 0);
    go(3'b110, 0);
    repeat (3) cycle(3'b000, 11'd0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
    cycle(3'b000, 11'd0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h0);
    cycle(3'b000, 11'd0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0);
    cycle(3'b000, 11'd0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0);
    cycle(3'b000, 11'd0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      cycle(3'($urandom_range(0, 7)), 11'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), 1'($urandom), 4'($urandom), $urandom);
    end

    // Asynchronous reset while stalled at 1602
    go(3'b110, 1602);
    cycle(3'b000, 11'd0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
    cycle(3'b000, 11'd0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("async_reset_mid_wait");
    m_started = 0; m_wait = 0; m_addr = 0;
    @(posedge clk);
    #3;
    check_reset("reset_held");
    rst_n = 1'b1;
    cycle(3'b110, 11'd77, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0);
    cycle(3'b110, 11'd77, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0);
    go(3'b000, 0);

    @(posedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
